// File: rtl/vec_strided_lsu.sv
// Strided vector load/store unit: walks vl elements at base+i*stride over a native memory port.
// Latency: 3 cycles per element plus responder wait cycles, plus one DONE cycle.
// Backpressure: holds the request stable while mem_ready is low; no timeout.
module vec_strided_lsu (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_store,
  input  logic [31:0] base_addr,
  input  logic [31:0] stride,
  input  logic [5:0]  vl,
  input  logic [1:0]  sew,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  elem_idx,
  output logic        elem_we,
  output logic [31:0] elem_wdata,
  input  logic [31:0] elem_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_NEXT, S_DONE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  state_t      state_q, state_d;
  mem_req_t    req_q;
  logic        is_store_q;
  logic [31:0] stride_q;
  logic [5:0]  vl_q;
  logic [1:0]  sew_q;
  logic [4:0]  idx_q;
  logic [31:0] cur_addr_q;
  logic        misalign;
  logic        last_elem;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  assign misalign  = ((sew_q == 2'b01) && cur_addr_q[0]) ||
                     ((sew_q == 2'b10) && (cur_addr_q[1:0] != 2'b00));
  assign last_elem = ({1'b0, idx_q} == (vl_q - 6'd1));

  assign busy      = (state_q == S_ADDR) || (state_q == S_WAIT) || (state_q == S_NEXT);
  assign done      = (state_q == S_DONE);
  assign elem_idx  = idx_q;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_wstrb = req_q.wstrb;

  // Store element is replicated so every byte lane carries it; the strobe picks the lane.
  always_comb begin
    st_data = elem_rdata;
    st_strb = 4'b1111;
    case (sew_q)
      2'b00: begin
        st_data = {4{elem_rdata[7:0]}};
        st_strb = 4'b0001 << cur_addr_q[1:0];
      end
      2'b01: begin
        st_data = {2{elem_rdata[15:0]}};
        st_strb = 4'b0011 << cur_addr_q[1:0];
      end
      default: begin
        st_data = elem_rdata;
        st_strb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_shift = mem_rdata >> {cur_addr_q[1:0], 3'b000};
    case (sew_q)
      2'b00:   ld_data = {24'd0, ld_shift[7:0]};
      2'b01:   ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = ((sew == 2'b11) || (vl == 6'd0)) ? S_DONE : S_ADDR;
      S_ADDR: state_d = misalign ? S_DONE : S_WAIT;
      S_WAIT: if (mem_ready) state_d = S_NEXT;
      S_NEXT: state_d = last_elem ? S_DONE : S_ADDR;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_q      <= '0;
      mem_valid  <= 1'b0;
      is_store_q <= 1'b0;
      stride_q   <= '0;
      vl_q       <= '0;
      sew_q      <= '0;
      idx_q      <= '0;
      cur_addr_q <= '0;
      err        <= 1'b0;
      elem_we    <= 1'b0;
      elem_wdata <= '0;
    end else begin
      elem_we <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          is_store_q <= is_store;
          stride_q   <= stride;
          vl_q       <= vl;
          sew_q      <= sew;
          idx_q      <= '0;
          cur_addr_q <= base_addr;
          err        <= (sew == 2'b11);
        end
        S_ADDR: begin
          if (misalign) begin
            err <= 1'b1;
          end else begin
            mem_valid  <= 1'b1;
            req_q.addr <= {cur_addr_q[31:2], 2'b00};
            req_q.wdata <= is_store_q ? st_data : 32'd0;
            req_q.wstrb <= is_store_q ? st_strb : 4'b0000;
          end
        end
        S_WAIT: if (mem_ready) begin
          mem_valid   <= 1'b0;
          req_q.wstrb <= 4'b0000;
          if (!is_store_q) begin
            elem_we    <= 1'b1;
            elem_wdata <= ld_data;
          end
        end
        S_NEXT: if (!last_elem) begin
          idx_q      <= idx_q + 5'd1;
          cur_addr_q <= cur_addr_q + stride_q;
        end
        S_DONE: err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_strided_lsu.sv
// Bench for vec_strided_lsu: directed and random strided loads/stores against an arithmetic model.
`timescale 1ns/1ps
module tb_vec_strided_lsu;
  logic        clk = 1'b0;
  logic        resetn, start, is_store;
  logic [31:0] base_addr, stride;
  logic [5:0]  vl;
  logic [1:0]  sew;
  logic        busy, done, err, elem_we;
  logic [4:0]  elem_idx;
  logic [31:0] elem_wdata, elem_rdata;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  typedef struct packed {logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} txn_t;
  typedef struct packed {logic [4:0] idx; logic [31:0] data;} wr_t;

  txn_t        exp_txn[$], got_txn[$];
  wr_t         exp_we[$], got_we[$];
  logic [31:0] mem [0:255];
  logic [31:0] vrf [0:31];
  int          checks = 0, errors = 0, resp_delay = 0, viol = 0;

  always #5 clk = ~clk;

  vec_strided_lsu dut (
    .clk(clk), .resetn(resetn), .start(start), .is_store(is_store),
    .base_addr(base_addr), .stride(stride), .vl(vl), .sew(sew),
    .busy(busy), .done(done), .err(err), .elem_idx(elem_idx),
    .elem_we(elem_we), .elem_wdata(elem_wdata), .elem_rdata(elem_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  assign elem_rdata = vrf[elem_idx];

  // Responder: waits resp_delay cycles (random 0..3 when negative), logs each accepted request.
  initial begin
    int cnt;
    bit pending;
    txn_t t;
    mem_ready = 1'b0; mem_rdata = '0; pending = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        pending = 1'b0;
      end else if (mem_valid) begin
        if (!pending) begin
          pending = 1'b1;
          cnt = (resp_delay < 0) ? int'($urandom_range(0, 3)) : resp_delay;
        end
        if (cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[9:2]];
          t.addr = mem_addr; t.wdata = mem_wdata; t.wstrb = mem_wstrb;
          if (resetn) got_txn.push_back(t);
        end else cnt--;
      end else pending = 1'b0;
    end
  end

  always @(negedge clk) begin
    wr_t w;
    if (elem_we) begin
      w.idx = elem_idx; w.data = elem_wdata;
      got_we.push_back(w);
    end
    if (mem_valid && (done || !busy)) viol++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: element i lives at base + i*stride; stops at the first misaligned element.
  task automatic model_op(input bit st, input logic [31:0] base, input logic [31:0] strd,
                          input logic [5:0] n, input logic [1:0] sw,
                          output bit e_err, output bit e_mis);
    logic [31:0] a, word, mask, data, wd;
    int bytes, off;
    txn_t t;
    wr_t w;
    exp_txn.delete(); exp_we.delete();
    e_err = 0; e_mis = 0;
    if (sw == 2'b11) begin e_err = 1; return; end
    bytes = 1 << sw;
    mask = (bytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 32'd1);
    for (int i = 0; i < int'(n); i++) begin
      a = base + strd * i;
      if ((a % bytes) != 0) begin e_err = 1; e_mis = 1; return; end
      off = int'(a % 4);
      word = mem[a[9:2]];
      t.addr = a & 32'hFFFF_FFFC;
      if (st) begin
        data = vrf[i] & mask;
        wd = 0;
        for (int k = 0; k < 4 / bytes; k++) wd = wd | (data << (8 * bytes * k));
        t.wdata = wd;
        t.wstrb = 4'(((1 << bytes) - 1) << off);
      end else begin
        t.wdata = 0;
        t.wstrb = 4'b0000;
        w.idx = 5'(i);
        w.data = (word >> (8 * off)) & mask;
        exp_we.push_back(w);
      end
      exp_txn.push_back(t);
    end
  endtask

  task automatic run_op(input string tag, input bit st, input logic [31:0] base,
                        input logic [31:0] strd, input logic [5:0] n, input logic [1:0] sw,
                        input int poke_at);
    bit e_err, e_mis, got_done, got_err, b1;
    int lat, exp_lat;
    model_op(st, base, strd, n, sw, e_err, e_mis);
    got_txn.delete(); got_we.delete();
    is_store = st; base_addr = base; stride = strd; vl = n; sew = sw; start = 1'b1;
    lat = 0; got_done = 0; got_err = 0; b1 = 0;
    while (!got_done && lat < 2000) begin
      tick();
      lat++;
      start = (lat == poke_at);
      if (start) begin
        is_store = ~st; sew = 2'b11; vl = 6'd0; base_addr = 32'h0000_0123; stride = 32'd7;
      end
      if (lat == 1) b1 = busy;
      if (done) begin got_done = 1; got_err = err; end
    end
    start = 1'b0;
    chk({tag, ".done_seen"}, got_done, 1'b1);
    chk({tag, ".busy_early"}, b1, !(sw == 2'b11 || n == 0));
    chk({tag, ".busy_at_done"}, busy, 1'b0);
    chk({tag, ".err"}, got_err, e_err);
    if (resp_delay >= 0) begin
      exp_lat = 1 + exp_txn.size() * (3 + resp_delay) + int'(e_mis);
      chk({tag, ".latency"}, lat, exp_lat);
    end
    tick();
    chk({tag, ".done_pulse"}, done, 1'b0);
    chk({tag, ".n_req"}, got_txn.size(), exp_txn.size());
    chk({tag, ".n_we"}, got_we.size(), exp_we.size());
    for (int i = 0; i < exp_txn.size() && i < got_txn.size(); i++) begin
      chk($sformatf("%s.addr[%0d]", tag, i), got_txn[i].addr, exp_txn[i].addr);
      chk($sformatf("%s.strb[%0d]", tag, i), got_txn[i].wstrb, exp_txn[i].wstrb);
      if (st) chk($sformatf("%s.wdata[%0d]", tag, i), got_txn[i].wdata, exp_txn[i].wdata);
    end
    for (int i = 0; i < exp_we.size() && i < got_we.size(); i++) begin
      chk($sformatf("%s.we_idx[%0d]", tag, i), got_we[i].idx, exp_we[i].idx);
      chk($sformatf("%s.we_dat[%0d]", tag, i), got_we[i].data, exp_we[i].data);
    end
  endtask

  initial begin
    int sum_done, sum_we, sum_valid, wait_cnt;
    logic [1:0] rs;
    logic [31:0] rb, rstr;
    int bytes;
    resetn = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = '0; stride = '0; vl = '0; sew = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 32; i++) vrf[i] = $urandom;
    mem[100] = 32'h0403_0201;
    mem[101] = 32'h0807_0605;
    mem[110] = 32'h0050_0032;
    tick(); tick();
    chk("rst.mem_valid", mem_valid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.err", err, 1'b0);
    chk("rst.elem_we", elem_we, 1'b0);
    chk("rst.fields", {mem_addr, mem_wdata}, 64'd0);
    chk("rst.misc", {mem_wstrb, elem_idx, elem_wdata}, 41'd0);
    resetn = 1'b1;
    tick();

    resp_delay = 0;
    run_op("load_b8", 1'b0, 32'd400, 32'd3, 6'd3, 2'b00, 0);
    if (got_we.size() == 3) begin
      chk("load_b8.lit0", got_we[0].data, 32'h01);
      chk("load_b8.lit1", got_we[1].data, 32'h04);
      chk("load_b8.lit2", got_we[2].data, 32'h07);
      chk("load_b8.addr2", got_txn[2].addr, 32'd404);
    end
    run_op("load_s0", 1'b0, 32'd442, 32'd0, 6'd3, 2'b01, 0);
    if (got_we.size() == 3) chk("load_s0.lit", got_we[2].data, 32'h0050);
    vrf[0] = 32'h0000_BEEF;
    run_op("store_h", 1'b1, 32'd402, 32'd4, 6'd1, 2'b01, 0);
    if (got_txn.size() == 1) begin
      chk("store_h.lit_addr", got_txn[0].addr, 32'd400);
      chk("store_h.lit_wdata", got_txn[0].wdata, 32'hBEEF_BEEF);
      chk("store_h.lit_strb", got_txn[0].wstrb, 4'b1100);
    end
    run_op("misalign_w", 1'b0, 32'd402, 32'd4, 6'd4, 2'b10, 0);
    run_op("misalign_mid", 1'b0, 32'd400, 32'd3, 6'd4, 2'b01, 0);
    run_op("vl_zero", 1'b0, 32'd400, 32'd4, 6'd0, 2'b00, 0);
    run_op("sew_bad", 1'b1, 32'd400, 32'd4, 6'd3, 2'b11, 0);
    run_op("vl_max", 1'b0, 32'd0, 32'd4, 6'd32, 2'b10, 0);
    run_op("neg_stride", 1'b1, 32'h0000_0100, 32'hFFFF_FFFE, 6'd5, 2'b01, 0);
    resp_delay = 2;
    run_op("busy_poke", 1'b0, 32'd400, 32'd4, 6'd3, 2'b10, 3);
    run_op("store_slow", 1'b1, 32'd401, 32'd5, 6'd4, 2'b00, 0);

    // Stalled request is held, then abandoned by a reset pulse.
    resp_delay = 5;
    got_txn.delete(); got_we.delete();
    is_store = 1'b1; base_addr = 32'd400; stride = 32'd4; vl = 6'd2; sew = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    wait_cnt = 0;
    while (!mem_valid && wait_cnt < 10) begin tick(); wait_cnt++; end
    chk("stall.valid_seen", mem_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall.valid[%0d]", i), mem_valid, 1'b1);
      chk($sformatf("stall.ready[%0d]", i), mem_ready, 1'b0);
      chk($sformatf("stall.req[%0d]", i), {mem_addr, mem_wdata, mem_wstrb}, {32'd400, vrf[0], 4'b1111});
      tick();
    end
    resetn = 1'b0;
    tick();
    chk("rstmid.ctl", {mem_valid, mem_wstrb, elem_we, done, err, busy}, 9'd0);
    chk("rstmid.data", {mem_addr, mem_wdata}, 64'd0);
    chk("rstmid.elem", {elem_wdata, elem_idx}, 37'd0);
    resetn = 1'b1;
    sum_done = 0; sum_we = 0; sum_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      sum_done += int'(done); sum_we += int'(elem_we); sum_valid += int'(mem_valid);
    end
    chk("rstmid.no_done", sum_done, 0);
    chk("rstmid.no_we", sum_we, 0);
    chk("rstmid.no_valid", sum_valid, 0);
    chk("rstmid.no_txn", got_txn.size(), 0);

    resp_delay = -1;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 32; i++) vrf[i] = $urandom;
      rs = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      bytes = (rs == 2'b11) ? 1 : (1 << rs);
      rb = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) rb = rb & ~32'(bytes - 1);
      rstr = 32'($urandom_range(0, 16) * bytes);
      if ($urandom_range(0, 1) != 0) rstr = -rstr;
      if ($urandom_range(0, 7) == 0) rstr = 32'($urandom_range(0, 31));
      run_op($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), rb, rstr,
             6'($urandom_range(0, 32)), rs, 0);
    end

    chk("no_valid_outside_op", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
